// File: rtl/full_adder.sv
// Parameterised ripple-carry full adder with a combinational result and a
// one-cycle registered copy that clears asynchronously on reset.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Cin,
  output logic [WIDTH-1:0] o_Sum,
  output logic             o_Cout,
  output logic [WIDTH-1:0] o_Sum_r,
  output logic             o_Cout_r
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_d;
  logic             cout_q;

  assign carry[0] = i_Cin;

  // One 1-bit cell per bit; carry out of bit k is the carry in of bit k+1.
  for (genvar k = 0; k < WIDTH; k++) begin : g_cell
    logic p;
    assign p          = i_A[k] ^ i_B[k];
    assign sum_d[k]   = p ^ carry[k];
    assign carry[k+1] = (i_A[k] & i_B[k]) | (carry[k] & p);
  end

  assign cout_d = carry[WIDTH];

  assign o_Sum  = sum_d;
  assign o_Cout = cout_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign o_Sum_r  = sum_q;
  assign o_Cout_r = cout_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder at WIDTH=1 and WIDTH=8: combinational truth
// table, registered latency, asynchronous reset and carry-chain extremes.
module tb_full_adder;

  logic       clk;
  logic       clk_run;
  logic       rst_n;

  logic       a1, b1, cin1;
  logic       sum1, cout1, sum1_r, cout1_r;

  logic [7:0] a8, b8;
  logic       cin8;
  logic [7:0] sum8, sum8_r;
  logic       cout8, cout8_r;

  int n_vec;
  int n_err;

  full_adder #(.WIDTH(1)) u_fa1 (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_A      (a1),
    .i_B      (b1),
    .i_Cin    (cin1),
    .o_Sum    (sum1),
    .o_Cout   (cout1),
    .o_Sum_r  (sum1_r),
    .o_Cout_r (cout1_r)
  );

  full_adder #(.WIDTH(8)) u_fa8 (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_A      (a8),
    .i_B      (b8),
    .i_Cin    (cin8),
    .o_Sum    (sum8),
    .o_Cout   (cout8),
    .o_Sum_r  (sum8_r),
    .o_Cout_r (cout8_r)
  );

  // Clock / reset block: the clock can be held stopped via clk_run.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive1(input logic a, input logic b, input logic c);
    a1 = a; b1 = b; cin1 = c;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8 = a; b8 = b; cin8 = c;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec8_t;

  vec8_t vecs8[6];

  initial begin
    logic [7:0] exp_sum_tt;
    logic [7:0] exp_cout_tt;
    logic [2:0] idx;

    n_vec   = 0;
    n_err   = 0;
    clk_run = 1'b0;
    rst_n   = 1'b0;
    drive1(1'b0, 1'b0, 1'b0);
    drive8(8'h00, 8'h00, 1'b0);

    // Hand-computed expectations: {A+B+Cin} for WIDTH=8.
    vecs8[0] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs8[1] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
    vecs8[2] = '{a: 8'h5A, b: 8'h25, cin: 1'b0, sum: 8'h7F, cout: 1'b0};
    vecs8[3] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs8[4] = '{a: 8'h0F, b: 8'h01, cin: 1'b1, sum: 8'h11, cout: 1'b0};
    vecs8[5] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0};

    // Clock stopped, reset held: combinational path live, registers cleared.
    #2;
    drive1(1'b1, 1'b1, 1'b0);
    #1;
    check("rst_comb_sum",  sum1,    1'b0);
    check("rst_comb_cout", cout1,   1'b1);
    check("rst_sum_r",     sum1_r,  1'b0);
    check("rst_cout_r",    cout1_r, 1'b0);
    check("rst_sum8_r",    sum8_r,  8'h00);

    // WIDTH=1 exhaustive, index is {A,B,Cin}.
    exp_sum_tt  = 8'b1001_0110;
    exp_cout_tt = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      drive1(idx[2], idx[1], idx[0]);
      #10;
      check($sformatf("tt%0d_sum", i),  sum1,  exp_sum_tt[i]);
      check($sformatf("tt%0d_cout", i), cout1, exp_cout_tt[i]);
    end

    // Registered latency across reset release.
    clk_run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    drive1(1'b1, 1'b0, 1'b1);
    #1;
    check("pre_edge_sum_r",  sum1_r,  1'b0);
    check("pre_edge_cout_r", cout1_r, 1'b0);
    @(posedge clk);
    #1;
    check("edge_sum_r",  sum1_r,  1'b0);
    check("edge_cout_r", cout1_r, 1'b1);

    // Asynchronous reset pulse between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_cout_r", cout1_r, 1'b0);
    check("async_sum_r",  sum1_r,  1'b0);
    check("async_comb_cout", cout1, 1'b1);
    rst_n = 1'b1;
    #1;
    check("post_rel_cout_r", cout1_r, 1'b0);
    @(posedge clk);
    #1;
    check("reload_cout_r", cout1_r, 1'b1);
    check("reload_sum_r",  sum1_r,  1'b0);

    // WIDTH=8 carry chain and extremes, combinational then registered.
    foreach (vecs8[i]) begin
      @(negedge clk);
      drive8(vecs8[i].a, vecs8[i].b, vecs8[i].cin);
      #1;
      check($sformatf("w8_%0d_sum", i),  sum8,  vecs8[i].sum);
      check($sformatf("w8_%0d_cout", i), cout8, vecs8[i].cout);
      @(posedge clk);
      #1;
      check($sformatf("w8_%0d_sum_r", i),  sum8_r,  vecs8[i].sum);
      check($sformatf("w8_%0d_cout_r", i), cout8_r, vecs8[i].cout);
    end

    // Reset mid-run on WIDTH=8: registers clear, combinational result holds.
    @(negedge clk);
    drive8(8'hFF, 8'hFF, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("w8_async_sum_r",  sum8_r,  8'h00);
    check("w8_async_cout_r", cout8_r, 1'b0);
    check("w8_async_sum",    sum8,    8'hFF);
    check("w8_async_cout",   cout8,   1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("w8_reload_sum_r", sum8_r, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
